// File: rtl/traffic_pkg.sv
// traffic_pkg: shared phase encodings, legal lamp vectors, fault codes and monitor states
package traffic_pkg;

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2,
      S3 = 2'd3
   } phase_e;

   // Lamp vectors ordered {RA,YA,GA,RB,YB,GB}
   localparam logic [5:0] LV_S0 = 6'b001100;
   localparam logic [5:0] LV_S1 = 6'b010100;
   localparam logic [5:0] LV_S2 = 6'b100001;
   localparam logic [5:0] LV_S3 = 6'b100010;

   localparam logic [2:0] FC_NONE    = 3'd0;
   localparam logic [2:0] FC_ILLEGAL = 3'd1;
   localparam logic [2:0] FC_TRANS   = 3'd2;
   localparam logic [2:0] FC_SHORT_Y = 3'd3;
   localparam logic [2:0] FC_DWELL   = 3'd4;

   typedef enum logic [1:0] {
      ACQUIRE = 2'd0,
      MONITOR = 2'd1,
      FAULT   = 2'd2
   } mon_state_e;

endpackage

// File: rtl/lamp_vector_decoder.sv
// lamp_vector_decoder: maps a 6-bit lamp vector to its phase and flags whether it is legal
module lamp_vector_decoder
   import traffic_pkg::*;
(
   input  logic [5:0] vec,
   output logic       legal,
   output logic [1:0] phase
);

   // Only the four phase vectors are legal; anything else decodes to S0 with legal low
   always_comb begin
      phase = (vec == LV_S1) ? S1 : (vec == LV_S2) ? S2 : (vec == LV_S3) ? S3 : S0;
      legal = (vec == LV_S0) || (vec == LV_S1) || (vec == LV_S2) || (vec == LV_S3);
   end

endmodule

// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor: watches the controller lamps, checks vector legality, sequence and dwell, latches the first fault
module traffic_lamp_monitor
   import traffic_pkg::*;
#(
   parameter int MIN_YELLOW_CYC = 1,
   parameter int MAX_DWELL_CYC  = 255,
   parameter int FILTER_CYC     = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RA,
   input  logic       YA,
   input  logic       GA,
   input  logic       RB,
   input  logic       YB,
   input  logic       GB,
   input  logic       clear_fault,
   output logic [1:0] phase,
   output logic       phase_valid,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic       flash_req,
   output logic [7:0] fault_count
);

   logic [5:0]  vec_d, vec_q;
   logic        vld_q;
   logic        legal, ok, same, succ, short_y, dwell_to, ill_hit;
   logic [1:0]  dec_phase;
   logic [3:0]  ill_d, ill_q;
   logic [16:0] dwell_inc;
   logic [2:0]  mon_code, new_code;
   mon_state_e  state_d, state_q;
   logic [1:0]  phase_d, phase_q;
   logic [15:0] dwell_d, dwell_q;
   logic        first_d, first_q;
   logic        fault_d, fault_q, flash_q;
   logic [2:0]  code_d, code_q;
   logic [7:0]  cnt_d, cnt_q;

   assign vec_d = {RA, YA, GA, RB, YB, GB};

   lamp_vector_decoder u_dec (
      .vec   (vec_q),
      .legal (legal),
      .phase (dec_phase)
   );

   // Checks on the registered vector; vld_q masks the all-off value held just after reset
   always_comb begin
      ok        = vld_q & legal;
      ill_d     = (!vld_q || legal) ? 4'd0 : (&ill_q) ? ill_q : ill_q + 4'd1;
      ill_hit   = vld_q && !legal && (int'(ill_d) >= FILTER_CYC);
      dwell_inc = {1'b0, dwell_q} + 17'd1;
      same      = dec_phase == phase_q;
      succ      = dec_phase == 2'(phase_q + 2'd1);
      short_y   = succ && phase_q[0] && !first_q && (int'(dwell_inc) < MIN_YELLOW_CYC);
      dwell_to  = same && (MAX_DWELL_CYC != 0) && (int'(dwell_inc) == MAX_DWELL_CYC);
      mon_code  = ill_hit ? FC_ILLEGAL : !ok ? FC_NONE : (!same && !succ) ? FC_TRANS :
                  short_y ? FC_SHORT_Y : dwell_to ? FC_DWELL : FC_NONE;
   end

   // Monitor FSM: acquire the first legal phase, track the sequence, latch the first fault until cleared
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      dwell_d  = dwell_q;
      first_d  = first_q;
      fault_d  = fault_q;
      code_d   = code_q;
      cnt_d    = cnt_q;
      new_code = FC_NONE;
      case (state_q)
         ACQUIRE: begin
            if (ok) begin
               state_d = MONITOR;
               phase_d = dec_phase;
               dwell_d = 16'd0;
               first_d = 1'b1;
            end else if (ill_hit) begin
               new_code = FC_ILLEGAL;
            end
         end
         MONITOR: begin
            new_code = mon_code;
            if (mon_code == FC_NONE && ok) begin
               if (same) begin
                  dwell_d = (&dwell_q) ? dwell_q : dwell_q + 16'd1;
               end else begin
                  phase_d = dec_phase;
                  dwell_d = 16'd0;
                  first_d = 1'b0;
               end
            end
         end
         FAULT: begin
            if (clear_fault) begin
               state_d = ACQUIRE;
               fault_d = 1'b0;
               code_d  = FC_NONE;
            end
         end
         default: state_d = ACQUIRE;
      endcase
      if (new_code != FC_NONE) begin
         state_d = FAULT;
         fault_d = 1'b1;
         code_d  = new_code;
         cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 8'd1;
      end
   end

   // State and input registers, cleared immediately by rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_q   <= 6'd0;
         vld_q   <= 1'b0;
         ill_q   <= 4'd0;
         state_q <= ACQUIRE;
         phase_q <= 2'd0;
         dwell_q <= 16'd0;
         first_q <= 1'b0;
         fault_q <= 1'b0;
         flash_q <= 1'b0;
         code_q  <= FC_NONE;
         cnt_q   <= 8'd0;
      end else begin
         vec_q   <= vec_d;
         vld_q   <= 1'b1;
         ill_q   <= ill_d;
         state_q <= state_d;
         phase_q <= phase_d;
         dwell_q <= dwell_d;
         first_q <= first_d;
         fault_q <= fault_d;
         flash_q <= fault_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
      end
   end

   assign phase       = phase_q;
   assign phase_valid = state_q == MONITOR;
   assign fault       = fault_q;
   assign flash_req   = flash_q;
   assign fault_code  = code_q;
   assign fault_count = cnt_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// tb_traffic_lamp_monitor: vector table, directed corner sequences and a randomized scoreboard for three parameterizations
module tb_traffic_lamp_monitor;
   import traffic_pkg::*;

   typedef struct {
      logic [5:0] v;
      logic       c;
      int         ph, pv, flt, fc, cnt;
   } row_t;

   localparam logic [5:0] BG = 6'b001001;
   localparam logic [5:0] TWO_A = 6'b011100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic [5:0] lv  = 6'd0;
   logic [1:0] ph  [3];
   logic       pv  [3];
   logic       flt [3];
   logic       fl  [3];
   logic [2:0] fc  [3];
   logic [7:0] cnt [3];
   int         n_chk = 0;
   int         n_fail = 0;

   int p_min [3] = '{1, 3, 1};
   int p_max [3] = '{255, 10, 0};
   int p_fil [3] = '{1, 3, 1};

   int         m_st [3], m_ph [3], m_held [3], m_first [3], m_ill [3], m_code [3], m_cnt [3];
   logic [5:0] m_vec;
   bit         m_vld;

   always #5 clk = ~clk;

   traffic_lamp_monitor u0 (
      .clk(clk), .rst(rst), .RA(lv[5]), .YA(lv[4]), .GA(lv[3]), .RB(lv[2]), .YB(lv[1]), .GB(lv[0]),
      .clear_fault(clr), .phase(ph[0]), .phase_valid(pv[0]), .fault(flt[0]), .fault_code(fc[0]),
      .flash_req(fl[0]), .fault_count(cnt[0])
   );

   traffic_lamp_monitor #(.MIN_YELLOW_CYC(3), .MAX_DWELL_CYC(10), .FILTER_CYC(3)) u1 (
      .clk(clk), .rst(rst), .RA(lv[5]), .YA(lv[4]), .GA(lv[3]), .RB(lv[2]), .YB(lv[1]), .GB(lv[0]),
      .clear_fault(clr), .phase(ph[1]), .phase_valid(pv[1]), .fault(flt[1]), .fault_code(fc[1]),
      .flash_req(fl[1]), .fault_count(cnt[1])
   );

   traffic_lamp_monitor #(.MAX_DWELL_CYC(0)) u2 (
      .clk(clk), .rst(rst), .RA(lv[5]), .YA(lv[4]), .GA(lv[3]), .RB(lv[2]), .YB(lv[1]), .GB(lv[0]),
      .clear_fault(clr), .phase(ph[2]), .phase_valid(pv[2]), .fault(flt[2]), .fault_code(fc[2]),
      .flash_req(fl[2]), .fault_count(cnt[2])
   );

   function automatic logic [5:0] lv_of(input int p);
      return p == 0 ? LV_S0 : p == 1 ? LV_S1 : p == 2 ? LV_S2 : LV_S3;
   endfunction

   function automatic int phase_of(input logic [5:0] v);
      for (int p = 0; p < 4; p++) if (v == lv_of(p)) return p;
      return -1;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input int i, input int e_ph, input int e_pv,
                          input int e_flt, input int e_fc, input int e_cnt);
      string s;
      s = $sformatf("%s/u%0d", tag, i);
      chk({s, "/phase"}, int'(ph[i]), e_ph);
      chk({s, "/phase_valid"}, int'(pv[i]), e_pv);
      chk({s, "/fault"}, int'(flt[i]), e_flt);
      chk({s, "/flash_req"}, int'(fl[i]), e_flt);
      chk({s, "/fault_code"}, int'(fc[i]), e_fc);
      chk({s, "/fault_count"}, int'(cnt[i]), e_cnt);
   endtask

   task automatic cyc(input logic [5:0] v, input logic c);
      lv  = v;
      clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic [5:0] v, input int n);
      for (int k = 0; k < n; k++) cyc(v, 1'b0);
   endtask

   task automatic model_reset;
      m_vld = 1'b0;
      m_vec = 6'd0;
      for (int i = 0; i < 3; i++) begin
         m_st[i] = 0; m_ph[i] = 0; m_held[i] = 0; m_first[i] = 0;
         m_ill[i] = 0; m_code[i] = 0; m_cnt[i] = 0;
      end
   endtask

   task automatic do_reset;
      rst = 1'b1;
      lv  = LV_S0;
      clr = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // Reference: state 0 acquire, 1 monitor, 2 fault; held counts cycles already spent in the phase
   task automatic model_mon(input int i, input logic c);
      int p, code;
      bit hit;
      if (!m_vld) return;
      p = phase_of(m_vec);
      m_ill[i] = (p < 0) ? m_ill[i] + 1 : 0;
      hit = (p < 0) && (m_ill[i] >= p_fil[i]);
      code = 0;
      if (m_st[i] == 0) begin
         if (p >= 0) begin
            m_st[i] = 1; m_ph[i] = p; m_held[i] = 1; m_first[i] = 1;
         end else if (hit) code = 1;
      end else if (m_st[i] == 1) begin
         if (hit) code = 1;
         else if (p >= 0) begin
            if (p == m_ph[i]) begin
               if (p_max[i] != 0 && m_held[i] == p_max[i]) code = 4;
               else m_held[i]++;
            end else if (p == (m_ph[i] + 1) % 4) begin
               if (m_ph[i] % 2 == 1 && m_first[i] == 0 && m_held[i] < p_min[i]) code = 3;
               else begin
                  m_ph[i] = p; m_held[i] = 1; m_first[i] = 0;
               end
            end else code = 2;
         end
      end else if (c) begin
         m_st[i] = 0;
         m_code[i] = 0;
      end
      if (code != 0) begin
         m_st[i] = 2;
         m_code[i] = code;
         m_cnt[i] = (m_cnt[i] >= 255) ? 255 : m_cnt[i] + 1;
      end
   endtask

   task automatic model_step(input logic [5:0] v, input logic c);
      for (int i = 0; i < 3; i++) model_mon(i, c);
      m_vec = v;
      m_vld = 1'b1;
   endtask

   initial begin
      row_t tbl [$];
      logic [5:0] v;
      logic       c;
      int         cur;
      int         r;

      tbl.push_back('{LV_S0, 1'b0, 0, 0, 0, 0, 0});
      tbl.push_back('{LV_S0, 1'b0, 0, 1, 0, 0, 0});
      tbl.push_back('{LV_S0, 1'b0, 0, 1, 0, 0, 0});
      tbl.push_back('{LV_S0, 1'b0, 0, 1, 0, 0, 0});
      tbl.push_back('{LV_S0, 1'b0, 0, 1, 0, 0, 0});
      tbl.push_back('{LV_S1, 1'b0, 0, 1, 0, 0, 0});
      tbl.push_back('{LV_S2, 1'b0, 1, 1, 0, 0, 0});
      tbl.push_back('{LV_S2, 1'b0, 2, 1, 0, 0, 0});
      tbl.push_back('{LV_S2, 1'b0, 2, 1, 0, 0, 0});
      tbl.push_back('{LV_S2, 1'b0, 2, 1, 0, 0, 0});
      tbl.push_back('{LV_S3, 1'b0, 2, 1, 0, 0, 0});
      tbl.push_back('{LV_S0, 1'b0, 3, 1, 0, 0, 0});
      tbl.push_back('{LV_S0, 1'b0, 0, 1, 0, 0, 0});
      tbl.push_back('{BG,    1'b0, 0, 1, 0, 0, 0});
      tbl.push_back('{LV_S0, 1'b0, 0, 0, 1, 1, 1});
      tbl.push_back('{LV_S0, 1'b1, 0, 0, 0, 0, 1});
      tbl.push_back('{LV_S0, 1'b0, 0, 1, 0, 0, 1});
      tbl.push_back('{LV_S0, 1'b0, 0, 1, 0, 0, 1});
      tbl.push_back('{LV_S2, 1'b0, 0, 1, 0, 0, 1});
      tbl.push_back('{LV_S2, 1'b0, 0, 0, 1, 2, 2});
      tbl.push_back('{LV_S2, 1'b1, 0, 0, 0, 0, 2});
      tbl.push_back('{LV_S2, 1'b0, 2, 1, 0, 0, 2});
      tbl.push_back('{LV_S3, 1'b0, 2, 1, 0, 0, 2});
      tbl.push_back('{LV_S0, 1'b0, 3, 1, 0, 0, 2});
      tbl.push_back('{LV_S0, 1'b1, 0, 1, 0, 0, 2});
      tbl.push_back('{TWO_A, 1'b0, 0, 1, 0, 0, 2});
      tbl.push_back('{LV_S0, 1'b0, 0, 0, 1, 1, 3});

      // reset state
      rst = 1'b1;
      cyc(LV_S0, 1'b0);
      cyc(LV_S0, 1'b0);
      for (int i = 0; i < 3; i++) chk_all("reset", i, 0, 0, 0, 0, 0);
      rst = 1'b0;

      // vector table on the default-parameter instance
      foreach (tbl[k]) begin
         cyc(tbl[k].v, tbl[k].c);
         chk_all($sformatf("tbl%0d", k), 0, tbl[k].ph, tbl[k].pv, tbl[k].flt, tbl[k].fc, tbl[k].cnt);
      end

      // two-cycle glitch is filtered at FILTER_CYC=3 but faults at 1
      do_reset();
      hold(LV_S0, 3); hold(BG, 2); hold(LV_S0, 3);
      chk("glitch2/u1/fault", int'(flt[1]), 0);
      chk("glitch2/u1/phase_valid", int'(pv[1]), 1);
      chk("glitch2/u0/fault_code", int'(fc[0]), 1);
      chk("glitch2/u0/fault_count", int'(cnt[0]), 1);
      do_reset();
      hold(LV_S0, 2); hold(BG, 3); hold(LV_S0, 2);
      chk_all("glitch3", 1, 0, 0, 1, 1, 1);

      // short yellow after a full phase, then the same as the first acquired phase
      do_reset();
      cyc(LV_S2, 1'b0); cyc(LV_S3, 1'b0); cyc(LV_S3, 1'b0); cyc(LV_S0, 1'b0); cyc(LV_S0, 1'b0);
      chk_all("shorty", 1, 3, 0, 1, 3, 1);
      chk_all("shorty_min1", 0, 0, 1, 0, 0, 0);
      do_reset();
      cyc(LV_S3, 1'b0); cyc(LV_S3, 1'b0); cyc(LV_S0, 1'b0); cyc(LV_S0, 1'b0);
      chk_all("shorty_first", 1, 0, 1, 0, 0, 0);
      cyc(LV_S1, 1'b0); cyc(LV_S2, 1'b0); cyc(LV_S2, 1'b0);
      chk_all("shorty_s1", 1, 1, 0, 1, 3, 1);

      // dwell timeout at 10, at 255, and disabled
      do_reset();
      hold(LV_S0, 12);
      chk_all("dwell10", 1, 0, 0, 1, 4, 1);
      hold(LV_S0, 988);
      chk_all("dwell_off", 2, 0, 1, 0, 0, 0);
      chk_all("dwell255", 0, 0, 0, 1, 4, 1);

      // saturating fault count, then asynchronous reset while faulted
      do_reset();
      for (int k = 0; k < 300; k++) begin
         cyc(6'd0, 1'b0);
         cyc(6'd0, 1'b1);
      end
      cyc(6'd0, 1'b0);
      chk_all("sat", 0, 0, 0, 1, 1, 255);
      chk("sat/u1/fault_count", int'(cnt[1]), 255);
      #3;
      rst = 1'b1;
      #1;
      chk_all("async_rst", 0, 0, 0, 0, 0, 0);
      chk("async_rst/u1/fault_count", int'(cnt[1]), 0);
      @(posedge clk);
      #1;

      // randomized stimulus against the reference model
      do_reset();
      cur = 0;
      for (int n = 0; n < 2000; n++) begin
         r = int'($urandom_range(0, 99));
         if (r >= 65 && r < 88) cur = (cur + 1) % 4;
         else if (r >= 88 && r < 94) cur = int'($urandom_range(0, 3));
         v = (r >= 96) ? 6'($urandom) : lv_of(cur);
         c = ($urandom_range(0, 9) == 0);
         cyc(v, c);
         model_step(v, c);
         for (int i = 0; i < 3; i++)
            chk_all($sformatf("rand%0d", n), i, m_ph[i], int'(m_st[i] == 1), int'(m_st[i] == 2), m_code[i], m_cnt[i]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/traffic_lamp_monitor.md
Name: traffic_lamp_monitor

Overview:
- Independent conflict monitor on the six lamp outputs of the intersection controller.
- Decodes the lamp vector back into a phase and checks that the vector is legal.
- Checks phase-sequence order, minimum yellow dwell and maximum phase dwell.
- Latches the first fault and its code, and raises flash_req so board logic can force all-red flash. The controller is never modified by this block.

Parameters:
- MIN_YELLOW_CYC, 1, minimum cycles a yellow phase (S1/S3) must be held.
- MAX_DWELL_CYC, 255, maximum consecutive cycles in any one phase; 0 disables the check.
- FILTER_CYC, 1, consecutive cycles an illegal lamp vector must persist before it faults (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- RA, YA, GA  in  1 each  approach A red/yellow/green lamps
- RB, YB, GB  in  1 each  approach B red/yellow/green lamps
- clear_fault  in  1  synchronous fault clear, one-cycle pulse
- phase  out  2  last legal decoded phase: 00 S0, 01 S1, 10 S2, 11 S3
- phase_valid  out  1  high while in MONITOR
- fault  out  1  latched fault flag
- fault_code  out  3  first-fault cause: 0 none, 1 illegal vector, 2 illegal transition, 3 short yellow, 4 dwell timeout
- flash_req  out  1  equals fault, registered
- fault_count  out  8  saturating count of faults since rst

Behaviour:
- Reset values: all outputs 0; FSM in ACQUIRE; all counters 0.
- Input stage: the 6-bit vector {RA,YA,GA,RB,YB,GB} is registered every cycle.
  - All checks run on the registered copy.
  - Fault/phase outputs update on the following edge, giving 2-edge latency from pin to output.
- Legal vectors:
  - S0 = 001100 (GA,RB)
  - S1 = 010100 (YA,RB)
  - S2 = 100001 (RA,GB)
  - S3 = 100010 (RA,YB)
  - Any other vector is illegal, including all-off, both-green and multiple lamps on one approach.
- Illegal filter: 4-bit counter increments on each illegal vector and clears on any legal vector. The fault fires when the counter reaches FILTER_CYC.
- FSM states:
  - ACQUIRE: wait for the first legal vector. Load phase, clear the dwell counter, set first_phase=1, go to MONITOR. No transition or yellow check applies here. An illegal vector passing the filter goes to FAULT.
  - MONITOR, each cycle:
    - Same phase: increment dwell_cnt (saturating 16-bit).
    - Legal successor (S0→S1, S1→S2, S2→S3, S3→S0): update phase, clear dwell_cnt, clear first_phase.
    - Any other change: illegal transition, code 2.
    - Leaving S1 or S3 with dwell_cnt+1 < MIN_YELLOW_CYC and first_phase=0: code 3.
    - dwell_cnt+1 == MAX_DWELL_CYC while the phase is unchanged and MAX_DWELL_CYC != 0: code 4.
  - FAULT:
    - fault=1, flash_req=1, phase_valid=0, phase holds its last value.
    - The vector is still sampled, but no further codes are recorded.
    - clear_fault → ACQUIRE; fault, flash_req and fault_code return to 0 on that edge.
- Priority when several faults arise in one cycle: code 1 > 2 > 3 > 4.
- fault_count increments once per MONITOR/ACQUIRE→FAULT entry and saturates at 255. Only rst clears it.
- clear_fault:
  - Outside FAULT it is ignored.
  - If asserted in the same cycle a new fault would be detected while in FAULT, clear wins; the new condition is re-evaluated from ACQUIRE.
- rst mid-operation: immediate return to reset values regardless of state, including an in-progress filter count.

Decomposition:
- Shared package traffic_pkg:
  - phase encodings S0..S3 (shared with the controller).
  - 6-bit legal lamp vector constants.
  - fault_code constants FC_NONE, FC_ILLEGAL, FC_TRANS, FC_SHORT_Y, FC_DWELL.
  - monitor FSM state enum.
- One natural sub-module: lamp_vector_decoder. It is combinational: 6-bit vector → {legal, phase[1:0]}. It is reusable by the bench scoreboard.

Test Plan:
- Legal cycle: drive S0×5, S1×1, S2×4, S3×1, S0, with defaults → phase tracks 00,01,10,11,00 two edges late; fault stays 0; phase_valid=1 from the third edge.
- Conflict: in MONITOR drive 001001 (both green) for 1 cycle → fault=1, fault_code=1, flash_req=1 two edges later, fault_count=1. Repeat with FILTER_CYC=3 and a 2-cycle glitch → no fault.
- Skipped yellow: S0×3 then S2 → fault_code=2. Then pulse clear_fault → fault=0, FSM in ACQUIRE, phase_valid=0 until the next legal vector.
- Short yellow with MIN_YELLOW_CYC=3: S2, S3×2, S0 → fault_code=3. Same sequence as the first phase after ACQUIRE → no fault.
- Dwell timeout with MAX_DWELL_CYC=10: hold S0 for 12 cycles → fault_code=4 on the 10th cycle in S0. With MAX_DWELL_CYC=0, hold 1000 cycles → no fault.
- Reset/saturation: force 300 fault/clear pairs → fault_count=255. Assert rst mid-FAULT → all outputs 0 asynchronously and fault_count=0.
